fdiv16_iter: RTL and testbench
==============================

// Module: fdiv16_iter
// PURPOSE
// - Sequential IEEE-754 half-precision divider: result = x / y.
// - Companion (inverse) of the combinational fma16 multiply path: restoring radix-2, one quotient bit/cycle.
// - Shares fma16 roundmode encoding and 4-bit flags width; sits beside fma16 in the FP execute stage.
// - valid/ready handshake on both sides.
// PARAMETERS
// - QBITS  14  quotient bits generated: 11 significand + guard + round + 1 normalisation slack (min 14)
// PORTS
// - clk        in   1   clock, all state updates on posedge
// - reset_n    in   1   synchronous active-low reset
// - in_valid   in   1   operands valid
// - in_ready   out  1   divider idle, can accept
// - x          in   16  dividend, fp16
// - y          in   16  divisor, fp16
// - roundmode  in   2   00 RZ, 01 RNE, 10 RP(+inf), 11 RN(-inf); sampled at accept
// - out_valid  out  1   result/flags valid
// - out_ready  in   1   consumer accepts result
// - result     out  16  quotient, fp16
// - flags      out  4   {NV, DZ, OF, NX}
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state IDLE; in_ready=1, out_valid=0, result=16'h0000, flags=4'h0. Reset mid-operation aborts it; no result emitted.
// - FSM: IDLE -> DIV -> RND -> DONE -> IDLE.
//   - IDLE: in_ready=1. in_valid&in_ready latches x, y, roundmode -> DIV.
//   - DIV: QBITS cycles. Partial remainder R (13b) starts as {1,Xm}; each cycle R-D>=0 ? (q=1, R=R-D) : q=0; R<<=1.
//   - RND: normalise, round, pack -> DONE.
//   - DONE: out_valid=1; result/flags held stable until out_ready. Transfer -> IDLE.
// - Latency: accept at cycle 0; out_valid rises at cycle QBITS+2 (16 by default). No overlap: in_ready=0 outside IDLE.
// - Arithmetic:
//   - sign = Xs^Ys.
//   - Eq = Xe - Ye + 15, signed 7-bit.
//   - q[QBITS-1]=0 -> shift left 1, Eq-=1.
//   - Significand = top 11 bits; G, R = next two bits; S = |remaining q bits | (R!=0).
//   - Rounding increment identical to fma16: RZ none; RNE G&(R|S|lsb); RP ~sign&NX; RN sign&NX.
//   - Mantissa carry-out -> exponent+1. NX = G|R|S.
// - Overflow (Eq>30 after rounding): OF=1, NX=1.
//   - RNE -> inf.
//   - RZ -> 0x7BFF | sign.
//   - RP: inf if positive, max finite if negative.
//   - RN: mirror of RP.
// - Underflow (Eq<1): flush to signed zero, NX=1, no subnormal output.
// - Operand classes (exp 0 = zero, frac ignored; exp 31 = inf/NaN):
//   - NaN in, 0/0, inf/inf -> 16'h7E00, NV=1.
//   - finite/0 -> signed inf, DZ=1.
//   - inf/finite -> signed inf.
//   - finite/inf, 0/nonzero -> signed zero.
//   - All with flags otherwise 0.
// - out_ready high in same cycle out_valid rises: transfer completes that edge; in_ready asserted next cycle.
// CONFIGURATION
// - FDIV16_EARLY_OUT_EN defined: special operands (any zero/inf/NaN) skip DIV; IDLE -> RND -> DONE, out_valid at cycle 2.
// - Undefined: all operations take the full QBITS+2 latency.
// - Result values and flags identical either way.
// STRUCTURE
// - Package fp16_pkg:
//   - BIAS=15, EXP_MAX=31
//   - QNAN=16'h7E00, MAXF=16'h7BFF
//   - typedef enum logic [1:0] rm_t {RM_RZ, RM_RNE, RM_RP, RM_RN}
//   - flag bit indices FL_NV=3, FL_DZ=2, FL_OF=1, FL_NX=0
//   - typedef enum state_t {IDLE, DIV, RND, DONE}
//   - typedef struct fp16_t {sign, exp[4:0], frac[9:0]}
// - Sub-module fp16_round (combinational): {sign, Eq, sig11, G, R, S, roundmode} -> {packed fp16, OF, NX}. Instantiated once in RND.
// - Top holds FSM, iteration counter ($clog2(QBITS+1) bits), remainder/quotient registers.
// TESTING
// - 0x4200/0x3E00 (3.0/1.5), RNE -> 0x4000, flags 0x0, out_valid exactly 16 cycles after accept.
// - 0x3C00/0x4200 (1/3): RNE -> 0x3555 NX; RZ -> 0x3555 NX; RP -> 0x3556 NX; 0xBC00/0x4200 RN -> 0xB556 NX.
// - 0x3C00/0x0000 -> 0x7C00 DZ.
// - 0x0000/0x0000 -> 0x7E00 NV.
// - 0x7E00/0x3C00 -> 0x7E00 NV.
// - 0x7BFF/0x1400: RNE -> 0x7C00 flags {OF,NX}; RZ -> 0x7BFF {OF,NX}. 0x0400/0x7800 -> 0x0000 NX.
// - Backpressure: out_ready low 5 cycles after out_valid -> result/flags stable, in_ready=0, second in_valid not accepted until transfer.
// - Reset at cycle 6 of a divide -> next cycle in_ready=1, out_valid=0; following 0x4200/0x3E00 completes correctly.

Source files
------------

// File: rtl/fdiv16_iter_pkg.sv
// fp16 constants, types and helpers shared by the fdiv16_iter divider and its rounding stage.
package fp16_pkg;

  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] MAXF = 16'h7BFF;

  typedef enum logic [1:0] {RM_RZ, RM_RNE, RM_RP, RM_RN} rm_t;

  localparam int FL_NV = 3;
  localparam int FL_DZ = 2;
  localparam int FL_OF = 1;
  localparam int FL_NX = 0;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  // Zero (any fraction) or inf/NaN: anything that bypasses the significand divide.
  function automatic logic is_special(input fp16_t v);
    return (v.exp == 5'd0) || (v.exp == 5'(EXP_MAX));
  endfunction

endpackage

// File: rtl/fdiv16_iter_if.sv
// Operand/result valid-ready bundle for fdiv16_iter; slave = divider, master = producer/consumer.
interface fdiv16_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  modport slave (
    input  in_valid, x, y, roundmode, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, x, y, roundmode, out_ready,
    input  in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fdiv16_iter_round.sv
// fp16_round: round a normalised quotient (sign, biased exponent, 11-bit significand, G/R/S) and pack it.
module fp16_round
  import fp16_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [6:0]  eq_i,
  input  logic [10:0]        sig_i,
  input  logic               g_i,
  input  logic               r_i,
  input  logic               s_i,
  input  rm_t                rm_i,
  output logic [15:0]        res_o,
  output logic               of_o,
  output logic               nx_o
);

  logic              inc;
  logic [11:0]       mant;
  logic [9:0]        frac;
  logic signed [6:0] exp_r;

  always_comb begin
    nx_o = g_i | r_i | s_i;
    of_o = 1'b0;
    unique case (rm_i)
      RM_RNE:  inc = g_i & (r_i | s_i | sig_i[0]);
      RM_RP:   inc = ~sign_i & nx_o;
      RM_RN:   inc = sign_i & nx_o;
      default: inc = 1'b0;
    endcase

    // A carry out of the significand renormalises to 1.0 and bumps the exponent.
    mant  = {1'b0, sig_i} + {11'd0, inc};
    frac  = mant[11] ? mant[10:1] : mant[9:0];
    exp_r = eq_i + $signed({6'd0, mant[11]});
    res_o = {sign_i, exp_r[4:0], frac};

    if (exp_r > 7'sd30) begin
      of_o = 1'b1;
      nx_o = 1'b1;
      unique case (rm_i)
        RM_RZ:   res_o = {sign_i, MAXF[14:0]};
        RM_RP:   res_o = sign_i ? {1'b1, MAXF[14:0]} : {1'b0, 5'h1F, 10'd0};
        RM_RN:   res_o = sign_i ? {1'b1, 5'h1F, 10'd0} : {1'b0, MAXF[14:0]};
        default: res_o = {sign_i, 5'h1F, 10'd0};
      endcase
    end else if (exp_r < 7'sd1) begin
      res_o = {sign_i, 15'd0};
      nx_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fdiv16_iter.sv
// fdiv16_iter: sequential fp16 divider, restoring radix-2, one quotient bit per cycle.
// Define FDIV16_EARLY_OUT_EN to let zero/inf/NaN operands skip the iteration phase.
module fdiv16_iter
  import fp16_pkg::*;
#(
  parameter int QBITS = 14
)(
  input  logic          clk,
  input  logic          reset_n,
  fdiv16_iter_if.slave  bus
);

  localparam int CW = $clog2(QBITS + 1);

  state_t            state_q, state_d;
  fp16_t             x_q, x_d, y_q, y_d;
  rm_t               rm_q, rm_d;
  logic [12:0]       rem_q, rem_d;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       res_q, res_d;
  logic [3:0]        flags_q, flags_d;

  logic              sign, hi, is_spec, rnd_of, rnd_nx;
  logic [QBITS-1:0]  nq;
  logic signed [6:0] eq;
  logic [12:0]       dvs;
  logic [15:0]       spec_res, rnd_res;
  logic [3:0]        spec_flags;
  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.flags     = flags_q;

  assign dvs  = {2'b00, 1'b1, y_q.frac};
  assign sign = x_q.sign ^ y_q.sign;

  // Operand classification and the fixed results of the special cases.
  always_comb begin
    x_zero     = (x_q.exp == 5'd0);
    y_zero     = (y_q.exp == 5'd0);
    x_inf      = (x_q.exp == 5'(EXP_MAX)) && (x_q.frac == 10'd0);
    y_inf      = (y_q.exp == 5'(EXP_MAX)) && (y_q.frac == 10'd0);
    x_nan      = (x_q.exp == 5'(EXP_MAX)) && (x_q.frac != 10'd0);
    y_nan      = (y_q.exp == 5'(EXP_MAX)) && (y_q.frac != 10'd0);
    spec_res   = 16'd0;
    spec_flags = 4'd0;
    is_spec    = 1'b1;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_res          = QNAN;
      spec_flags[FL_NV] = 1'b1;
    end else if (x_inf) begin
      spec_res = {sign, 5'h1F, 10'd0};
    end else if (y_zero) begin
      spec_res          = {sign, 5'h1F, 10'd0};
      spec_flags[FL_DZ] = 1'b1;
    end else if (y_inf || x_zero) begin
      spec_res = {sign, 15'd0};
    end else begin
      is_spec = 1'b0;
    end
  end

  // Quotient of two normal significands lies in (0.5, 2); a clear top bit means one left shift.
  always_comb begin
    hi = quo_q[QBITS-1];
    nq = hi ? quo_q : {quo_q[QBITS-2:0], 1'b0};
    eq = 7'({2'b00, x_q.exp}) - 7'({2'b00, y_q.exp}) + 7'(BIAS) - {6'd0, ~hi};
  end

  fp16_round u_round (
    .sign_i (sign),
    .eq_i   (eq),
    .sig_i  (nq[QBITS-1 -: 11]),
    .g_i    (nq[QBITS-12]),
    .r_i    (nq[QBITS-13]),
    .s_i    ((|nq[QBITS-14:0]) | (|rem_q)),
    .rm_i   (rm_q),
    .res_o  (rnd_res),
    .of_o   (rnd_of),
    .nx_o   (rnd_nx)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rm_d    = rm_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d   = bus.x;
          y_d   = bus.y;
          rm_d  = rm_t'(bus.roundmode);
          rem_d = {2'b00, 1'b1, bus.x[9:0]};
          quo_d = '0;
          cnt_d = '0;
`ifdef FDIV16_EARLY_OUT_EN
          state_d = (is_special(bus.x) || is_special(bus.y)) ? RND : DIV;
`else
          state_d = DIV;
`endif
        end
      end
      DIV: begin
        if (rem_q >= dvs) begin
          quo_d = {quo_q[QBITS-2:0], 1'b1};
          rem_d = (rem_q - dvs) << 1;
        end else begin
          quo_d = {quo_q[QBITS-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QBITS - 1)) state_d = RND;
      end
      RND: begin
        if (is_spec) begin
          res_d   = spec_res;
          flags_d = spec_flags;
        end else begin
          res_d          = rnd_res;
          flags_d        = 4'd0;
          flags_d[FL_OF] = rnd_of;
          flags_d[FL_NX] = rnd_nx;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rm_q    <= RM_RZ;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rm_q    <= rm_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_fdiv16_iter.sv
// tb_fdiv16_iter: directed and randomized checks of fdiv16_iter against an exact-division reference model.
module tb_fdiv16_iter;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  fdiv16_iter_if bus ();

  fdiv16_iter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  rm;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  // Reference: exact integer quotient of the significands, rounded from the true remainder.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                                  output logic [15:0] r, output logic [3:0] f);
    logic s;
    int ea, eb, fa, fb, mx, my, e, sh, num, q, rem, ebias;
    bit inc, inexact, an, bn, ai, bi, az, bz;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    az = (ea == 0);               bz = (eb == 0);
    f = 4'h0;
    if (an || bn || (az && bz) || (ai && bi)) begin r = 16'h7E00; f = 4'h8; return; end
    if (ai)        begin r = {s, 15'h7C00}; return; end
    if (bz)        begin r = {s, 15'h7C00}; f = 4'h4; return; end
    if (bi || az)  begin r = {s, 15'h0000}; return; end
    mx = 1024 + fa;
    my = 1024 + fb;
    sh = (mx >= my) ? 0 : 1;
    e  = ea - eb - sh;
    num = mx << (10 + sh);
    q   = num / my;
    rem = num % my;
    inexact = (rem != 0);
    case (rm)
      2'd1:    inc = (2 * rem > my) || ((2 * rem == my) && q[0]);
      2'd2:    inc = !s && inexact;
      2'd3:    inc = s && inexact;
      default: inc = 1'b0;
    endcase
    q = q + (inc ? 1 : 0);
    ebias = e + 15;
    if (q == 2048) begin q = 1024; ebias = ebias + 1; end
    if (ebias > 30) begin
      f = 4'h3;
      case (rm)
        2'd0:    r = {s, 15'h7BFF};
        2'd1:    r = {s, 15'h7C00};
        2'd2:    r = s ? 16'hFBFF : 16'h7C00;
        default: r = s ? 16'hFC00 : 16'h7BFF;
      endcase
    end else if (ebias < 1) begin
      r = {s, 15'h0000};
      f = 4'h1;
    end else begin
      r = {s, ebias[4:0], q[9:0]};
      f = inexact ? 4'h1 : 4'h0;
    end
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef FDIV16_EARLY_OUT_EN
    if (a[14:10] == 5'd0 || a[14:10] == 5'd31 || b[14:10] == 5'd0 || b[14:10] == 5'd31) return 2;
`endif
    return 16;
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [4:0] e;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 5'd0;
    else if (sel == 1) e = 5'd31;
    else               e = 5'($urandom_range(1, 30));
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  // Drives one operation; lat is the cycle (accept cycle = 0) in which out_valid is first seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm, input int hold,
                        output logic [15:0] r, output logic [3:0] f, output int lat, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    bus.x = a; bus.y = b; bus.roundmode = rm; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) to = 1'b1;
    r = bus.result;
    f = bus.flags;
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.result !== 16'h0000 || bus.flags !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: result=%h flags=%h, want 0000/0", bus.result, bus.flags);
    end
  endtask

  task automatic test_directed();
    vec_t v [15];
    logic [15:0] r;
    logic [3:0] f;
    int lat;
    bit to;
    v[0]  = '{16'h4200, 16'h3E00, 2'd1, 16'h4000, 4'h0};
    v[1]  = '{16'h3C00, 16'h4200, 2'd1, 16'h3555, 4'h1};
    v[2]  = '{16'h3C00, 16'h4200, 2'd0, 16'h3555, 4'h1};
    v[3]  = '{16'h3C00, 16'h4200, 2'd2, 16'h3556, 4'h1};
    v[4]  = '{16'hBC00, 16'h4200, 2'd3, 16'hB556, 4'h1};
    v[5]  = '{16'h3C00, 16'h0000, 2'd1, 16'h7C00, 4'h4};
    v[6]  = '{16'h0000, 16'h0000, 2'd1, 16'h7E00, 4'h8};
    v[7]  = '{16'h7E00, 16'h3C00, 2'd1, 16'h7E00, 4'h8};
    v[8]  = '{16'h7BFF, 16'h1400, 2'd1, 16'h7C00, 4'h3};
    v[9]  = '{16'h7BFF, 16'h1400, 2'd0, 16'h7BFF, 4'h3};
    v[10] = '{16'h0400, 16'h7800, 2'd1, 16'h0000, 4'h1};
    v[11] = '{16'hFC00, 16'h3C00, 2'd0, 16'hFC00, 4'h0};
    v[12] = '{16'h3C00, 16'hFC00, 2'd1, 16'h8000, 4'h0};
    v[13] = '{16'h7C00, 16'h7C00, 2'd2, 16'h7E00, 4'h8};
    v[14] = '{16'hFBFF, 16'h1400, 2'd2, 16'hFBFF, 4'h3};
    for (int i = 0; i < 15; i++) begin
      run_op(v[i].a, v[i].b, v[i].rm, 0, r, f, lat, to);
      checks++;
      if (to || r !== v[i].r || f !== v[i].f) begin
        errors++;
        $display("[TB] FAIL directed[%0d] %h/%h rm=%0d: got %h flags %h, want %h flags %h",
                 i, v[i].a, v[i].b, v[i].rm, r, f, v[i].r, v[i].f);
      end
      checks++;
      if (lat != exp_lat(v[i].a, v[i].b)) begin
        errors++;
        $display("[TB] FAIL latency[%0d]: out_valid in cycle %0d, want %0d", i, lat, exp_lat(v[i].a, v[i].b));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, er;
    logic [3:0] f, ef;
    logic [1:0] rm;
    int lat;
    bit to;
    for (int i = 0; i < 60; i++) begin
      a  = rand_fp();
      b  = rand_fp();
      rm = 2'($urandom_range(0, 3));
      ref_div(a, b, rm, er, ef);
      run_op(a, b, rm, $urandom_range(0, 3), r, f, lat, to);
      checks++;
      if (to || r !== er || f !== ef) begin
        errors++;
        $display("[TB] FAIL random[%0d] %h/%h rm=%0d: got %h flags %h, want %h flags %h", i, a, b, rm, r, f, er, ef);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    bus.x = 16'h3C00; bus.y = 16'h4200; bus.roundmode = 2'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.x = 16'h4200; bus.y = 16'h3E00; bus.roundmode = 2'd1;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== 16'h3556 || bus.flags !== 4'h1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: result=%h flags=%h ov=%b ir=%b, want 3556/1/1/0",
                 c, bus.result, bus.flags, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 16 || bus.result !== 16'h4000 || bus.flags !== 4'h0) begin
      errors++;
      $display("[TB] FAIL backpressure_second: cycle %0d result=%h flags=%h, want 16/4000/0", n, bus.result, bus.flags);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, er;
    logic [3:0] ef;
    int n;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = rand_fp();
      b = rand_fp();
      ref_div(a, b, 2'd1, er, ef);
      bus.x = a; bus.y = b; bus.roundmode = 2'd1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (bus.result !== er || bus.flags !== ef) begin
        errors++;
        $display("[TB] FAIL b2b_result[%0d] %h/%h: got %h flags %h, want %h flags %h", k, a, b, bus.result, bus.flags, er, ef);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_ready[%0d]: in_ready=%b out_valid=%b, want 1/0", k, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [3:0] f;
    int lat;
    bit to, seen;
    bus.x = 16'h3C00; bus.y = 16'h4200; bus.roundmode = 2'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL midreset_no_result: out_valid=1 after abort, want 0");
    end
    run_op(16'h4200, 16'h3E00, 2'd1, 0, r, f, lat, to);
    checks++;
    if (to || r !== 16'h4000 || f !== 4'h0 || lat != 16) begin
      errors++;
      $display("[TB] FAIL midreset_recover: got %h flags %h cycle %0d, want 4000 flags 0 cycle 16", r, f, lat);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = 16'h0000;
    bus.y         = 16'h0000;
    bus.roundmode = 2'd0;
    reset_n       = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
